// File: rtl/ift_alu_pipe.sv
// ---------------------------------------------------------------------------
// ift_alu_pipe
//
// Two-stage valid/ready pipelined ALU with information-flow-tracking taint
// propagation. Each operand carries a taint label; the result carries the
// propagated label. Taint is computed precisely for AND/OR style operations,
// where an untainted controlling value masks the other operand. It is
// computed conservatively (union of both labels) everywhere else.
//
// Optional feature macro: IFT_STICKY_EN
//   defined     : sticky_t accumulates (ORs) every emitted res_t, cleared by rst
//   not defined : sticky_t is tied to zero and no accumulator is built
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operand beat valid
//   in_ready   block can accept a beat (combinational)
//   op         operation select (0..13 defined, 14/15 reserved)
//   a, a_t     operand A and its taint label
//   b, b_t     operand B and its taint label
//   out_valid  result valid
//   out_ready  downstream accepts result
//   res        result data
//   res_t      result taint label
//   op_err     reserved opcode flag, qualified by out_valid
//   sticky_t   accumulated emitted taint (zero unless IFT_STICKY_EN)
// ---------------------------------------------------------------------------
module ift_alu_pipe #(
    parameter int WIDTH   = 8,
    parameter int TAINT_W = 32,
    parameter int OP_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    op,
    input  logic [WIDTH-1:0]   a,
    input  logic [TAINT_W-1:0] a_t,
    input  logic [WIDTH-1:0]   b,
    input  logic [TAINT_W-1:0] b_t,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   res,
    output logic [TAINT_W-1:0] res_t,
    output logic               op_err,
    output logic [TAINT_W-1:0] sticky_t
);

    localparam logic [OP_W-1:0] OP_AND  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_XOR  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_XNOR = OP_W'(3);
    localparam logic [OP_W-1:0] OP_SHL  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_SHR  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SSHR = OP_W'(6);
    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(7);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(8);
    localparam logic [OP_W-1:0] OP_MUL  = OP_W'(9);
    localparam logic [OP_W-1:0] OP_LT   = OP_W'(10);
    localparam logic [OP_W-1:0] OP_EQ   = OP_W'(11);
    localparam logic [OP_W-1:0] OP_LAND = OP_W'(12);
    localparam logic [OP_W-1:0] OP_LOR  = OP_W'(13);

    // Shift amounts at or above this value push every bit out of the word.
    localparam logic [WIDTH-1:0] SHIFT_LIMIT = WIDTH'(WIDTH);

    logic               s1_valid;
    logic [OP_W-1:0]    s1_op;
    logic [WIDTH-1:0]   s1_a;
    logic [TAINT_W-1:0] s1_a_t;
    logic [WIDTH-1:0]   s1_b;
    logic [TAINT_W-1:0] s1_b_t;

    logic               adv1;
    logic               adv2;
    logic               accept;

    logic [WIDTH-1:0]   calc_res;
    logic [TAINT_W-1:0] calc_t;
    logic               calc_err;

    logic               a_zero_clean;
    logic               b_zero_clean;
    logic               a_ones_clean;
    logic               b_ones_clean;
    logic               a_true_clean;
    logic               b_true_clean;
    logic               big_shift;

    // Handshake: S2 moves whenever its slot is empty or being drained, and S1
    // moves whenever it is empty or S2 is moving. A full stall therefore holds
    // exactly two beats, and accept-while-emit keeps the pipe full.
    always_comb begin
        adv2     = !out_valid || out_ready;
        adv1     = !s1_valid || adv2;
        in_ready = adv1;
        accept   = in_valid && adv1;
    end

    // Masking conditions: an untainted operand whose value alone decides the
    // outcome makes the result independent of the other (possibly tainted)
    // operand, so its label can be dropped.
    always_comb begin
        a_zero_clean = (s1_a == '0) && (s1_a_t == '0);
        b_zero_clean = (s1_b == '0) && (s1_b_t == '0);
        a_ones_clean = (&s1_a) && (s1_a_t == '0);
        b_ones_clean = (&s1_b) && (s1_b_t == '0);
        a_true_clean = (|s1_a) && (s1_a_t == '0);
        b_true_clean = (|s1_b) && (s1_b_t == '0);
        big_shift    = (s1_b >= SHIFT_LIMIT);
    end

    // Operation and taint computation on the S1 contents. Taint defaults to
    // the union of both labels and is only narrowed by the masking rules.
    // Any opcode outside the defined set is flagged as reserved.
    always_comb begin
        calc_res = '0;
        calc_t   = s1_a_t | s1_b_t;
        calc_err = 1'b0;
        case (s1_op)
            OP_AND: begin
                calc_res = s1_a & s1_b;
                if (a_zero_clean || b_zero_clean) calc_t = '0;
            end
            OP_OR: begin
                calc_res = s1_a | s1_b;
                if (a_ones_clean || b_ones_clean) calc_t = '0;
            end
            OP_XOR:  calc_res = s1_a ^ s1_b;
            OP_XNOR: calc_res = ~(s1_a ^ s1_b);
            OP_SHL:  calc_res = big_shift ? '0 : (s1_a << s1_b);
            OP_SHR:  calc_res = big_shift ? '0 : (s1_a >> s1_b);
            OP_SSHR: calc_res = big_shift ? {WIDTH{s1_a[WIDTH-1]}}
                                          : WIDTH'($signed(s1_a) >>> s1_b);
            OP_ADD:  calc_res = s1_a + s1_b;
            OP_SUB:  calc_res = s1_a - s1_b;
            OP_MUL: begin
                calc_res = s1_a * s1_b;
                if (a_zero_clean || b_zero_clean) calc_t = '0;
            end
            OP_LT:   calc_res = {{(WIDTH-1){1'b0}}, (s1_a < s1_b)};
            OP_EQ:   calc_res = {{(WIDTH-1){1'b0}}, (s1_a == s1_b)};
            OP_LAND: begin
                calc_res = {{(WIDTH-1){1'b0}}, ((|s1_a) && (|s1_b))};
                if (a_zero_clean || b_zero_clean) calc_t = '0;
            end
            OP_LOR: begin
                calc_res = {{(WIDTH-1){1'b0}}, ((|s1_a) || (|s1_b))};
                if (a_true_clean || b_true_clean) calc_t = '0;
            end
            default: begin
                calc_res = '0;
                calc_err = 1'b1;
            end
        endcase
    end

    // S1 occupancy. Whenever S1 advances it takes whatever is offered, so an
    // idle input simply lets the stage empty out.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (adv1) begin
            s1_valid <= in_valid;
        end
    end

    // S1 payload. Loaded only on an accepted beat; its content is meaningless
    // while s1_valid is low, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_op  <= op;
            s1_a   <= a;
            s1_a_t <= a_t;
            s1_b   <= b;
            s1_b_t <= b_t;
        end
    end

    // S2 output register. It drives the ports directly and only changes when
    // advancing, which keeps the result stable for the whole stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            res       <= '0;
            res_t     <= '0;
            op_err    <= 1'b0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                res    <= calc_res;
                res_t  <= calc_t;
                op_err <= calc_err;
            end
        end
    end

`ifdef IFT_STICKY_EN
    // Sticky taint: everything that has left the block since reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_t <= '0;
        end else if (out_valid && out_ready) begin
            sticky_t <= sticky_t | res_t;
        end
    end
`else
    // Without the accumulator the output reads as permanently clean.
    assign sticky_t = '0;
`endif

endmodule

// File: doc/ift_alu_pipe.md
Name: ift_alu_pipe

Overview:
- Parametrised, pipelined successor of the single-bit IFT binary-gate block.
- Takes two WIDTH-bit operands, each with a TAINT_W-bit taint label, and an opcode.
- Computes the selected binary operation and its propagated taint label through a 2-stage valid/ready pipeline.
- Sits between the instrumented datapath and downstream IFT checkers; taint rules are precise for AND/OR and conservative elsewhere.

Parameters:
- WIDTH, 8, operand/result data width (>=2)
- TAINT_W, 32, taint label width per signal
- OP_W, 4, opcode width (fixed encoding below; must be >=4)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat
- op  in  OP_W  operation select
- a  in  WIDTH  operand A
- a_t  in  TAINT_W  taint label of A
- b  in  WIDTH  operand B
- b_t  in  TAINT_W  taint label of B
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- res  out  WIDTH  result
- res_t  out  TAINT_W  result taint label
- op_err  out  1  reserved opcode flag, qualified by out_valid
- sticky_t  out  TAINT_W  accumulated emitted taint (see Optional Feature)

Behaviour:
- Reset (sync, active-high, one cycle): both stage valids=0, out_valid=0, res=0, res_t=0, op_err=0, sticky_t=0; in_ready=1 the cycle after reset deasserts.
- Reset mid-operation discards all in-flight beats with no output.
- Stage S1 registers {op,a,a_t,b,b_t} on accept (in_valid & in_ready).
- Stage S2 registers the computed {res,res_t,op_err}; its outputs drive the ports directly.
- Latency: beat accepted at edge N appears with out_valid=1 after edge N+1 when unstalled. Throughput 1 beat/cycle.
- Advance rules: adv2 = !out_valid | out_ready; adv1 = !s1_valid | adv2; in_ready = adv1 (combinational).
- Stall: while out_valid & !out_ready, res/res_t/op_err hold stable. S1 fills, then in_ready=0. Up to 2 beats are held with no loss and no duplication.
- Simultaneous accept and emit in one cycle is legal; the pipeline stays full.
- Opcodes: 0 AND, 1 OR, 2 XOR, 3 XNOR, 4 SHL (a<<b), 5 SHR logical, 6 SSHR arithmetic (a signed), 7 ADD mod 2^WIDTH, 8 SUB mod 2^WIDTH, 9 MUL low WIDTH bits, 10 LT unsigned, 11 EQ, 12 logical AND, 13 logical OR.
- Ops 10-13 give a 1-bit result zero-extended to WIDTH.
- Shift by b>=WIDTH: SHL/SHR give 0; SSHR gives all bits = a[WIDTH-1].
- Opcodes 14/15: res=0, res_t=a_t|b_t, op_err=1.
- Taint, default: res_t = a_t | b_t.
- Taint, AND and logical AND: if (a==0 & a_t==0) or (b==0 & b_t==0), res_t=0.
- Taint, OR: if (a=all-ones & a_t==0) or (b=all-ones & b_t==0), res_t=0.
- Taint, logical OR: if (a!=0 & a_t==0) or (b!=0 & b_t==0), res_t=0.
- Taint, MUL: untainted zero operand gives res_t=0.

Optional Feature:
- Macro: IFT_STICKY_EN.
- Defined: on every output handshake (out_valid & out_ready), sticky_t <= sticky_t | res_t; cleared only by rst.
- Not defined: sticky_t is constant 0 and no accumulator register exists.

Test Plan:
- Reset, then a=8'h00,a_t=0,b=8'h5A,b_t=32'h4, op=AND, out_ready=1 -> 2 cycles later res=00, res_t=0.
- a=8'hFF,a_t=32'h1,b=8'h0F,b_t=32'h2, op=ADD -> res=8'h0E, res_t=32'h3; op=OR with b=8'hFF,b_t=0 -> res=FF, res_t=0.
- op=SSHR, a=8'h80, b=8'd9 -> res=8'hFF; op=SHL, b=8'd8 -> res=0; op=14 -> op_err=1, res=0.
- Stream 4 beats with out_ready=0 -> exactly 2 accepted, then in_ready=0. Raise out_ready -> 2 results in order, then in_ready=1 and the remaining beats proceed unchanged.
- Assert rst while 2 beats are in flight -> out_valid=0 next cycle, no stale results after release.
- IFT_STICKY_EN: emit res_t 32'h1, 32'h10, 32'h0 -> sticky_t=32'h11. Without the macro -> sticky_t=0 throughout.
